// File: rtl/csr_regfile_pkg.sv
// Shared machine-mode CSR definitions: addresses, bit positions and mtvec modes.
package csr_regfile_pkg;

   localparam int CNT_HALF_W = 32;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MSTATUS_MPP_LO   = 11;

   localparam int IRQ_SW_BIT  = 3;
   localparam int IRQ_TMR_BIT = 7;
   localparam int IRQ_EXT_BIT = 11;

   typedef enum logic {
      MTVEC_DIRECT   = 1'b0,
      MTVEC_VECTORED = 1'b1
   } mtvec_mode_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit up-counter with independent half writes; any write suppresses that cycle's increment.
module csr_counter64
   import csr_regfile_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    inc,
   input  logic                    wr_lo,
   input  logic                    wr_hi,
   input  logic [CNT_HALF_W-1:0]   wr_data,
   output logic [2*CNT_HALF_W-1:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) value[CNT_HALF_W-1:0]            <= wr_data;
         if (wr_hi) value[2*CNT_HALF_W-1:CNT_HALF_W] <= wr_data;
      end else if (inc) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational read port, write-back commit, trap/mret
// state updates and the mcycle/minstret counters.
module csr_regfile
   import csr_regfile_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
   parameter int              HART_ID     = 0,
   parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [11:0]     rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_illegal,
   input  logic            rd_wr_intent,
   input  logic            wr_en,
   input  logic [11:0]     wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            instret_inc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret_valid,
   input  logic            irq_ext,
   input  logic            irq_tmr,
   input  logic            irq_sw,
   output logic [XLEN-1:0] trap_vector,
   output logic [XLEN-1:0] mepc_out,
   output logic            irq_pending
);

   localparam logic [XLEN-1:0] EPC_MASK   = ~XLEN'(3);
   localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);

   logic            st_mie, st_mpie;
   logic [2:0]      mie_q;
   logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [XLEN-1:0] mstatus_val, mie_val, mip_val, vec_base;
   logic [63:0]     mcycle_val, minstret_val;
   logic            wr_commit, impl;

   assign wr_commit = wr_en && !trap_valid && !mret_valid;

   always_comb begin
      mstatus_val = '0;
      mstatus_val[MSTATUS_MPP_LO +: 2] = 2'b11;
      mstatus_val[MSTATUS_MIE_BIT]     = st_mie;
      mstatus_val[MSTATUS_MPIE_BIT]    = st_mpie;
      mie_val = '0;
      mie_val[IRQ_SW_BIT]  = mie_q[0];
      mie_val[IRQ_TMR_BIT] = mie_q[1];
      mie_val[IRQ_EXT_BIT] = mie_q[2];
      mip_val = '0;
      mip_val[IRQ_SW_BIT]  = irq_sw;
      mip_val[IRQ_TMR_BIT] = irq_tmr;
      mip_val[IRQ_EXT_BIT] = irq_ext;
   end

   assign irq_pending = st_mie && |(mip_val & mie_val);
   assign mepc_out    = mepc_q;

   // Vectored offset applies only to interrupts, using this cycle's cause input.
   assign vec_base = {mtvec_q[XLEN-1:2], 2'b00};
   assign trap_vector = (mtvec_mode_e'(mtvec_q[0]) == MTVEC_VECTORED && trap_cause[XLEN-1])
                        ? vec_base + XLEN'({trap_cause[4:0], 2'b00}) : vec_base;

   always_comb begin
      rd_data = '0;
      impl    = 1'b1;
      case (rd_addr)
         CSR_MSTATUS:                          rd_data = mstatus_val;
         CSR_MISA:                             rd_data = MISA_VAL;
         CSR_MIE:                              rd_data = mie_val;
         CSR_MTVEC:                            rd_data = mtvec_q;
         CSR_MSCRATCH:                         rd_data = mscratch_q;
         CSR_MEPC:                             rd_data = mepc_q;
         CSR_MCAUSE:                           rd_data = mcause_q;
         CSR_MTVAL:                            rd_data = mtval_q;
         CSR_MIP:                              rd_data = mip_val;
         CSR_MCYCLE, CSR_CYCLE:                rd_data = mcycle_val[31:0];
         CSR_MCYCLEH, CSR_CYCLEH:              rd_data = mcycle_val[63:32];
         CSR_MINSTRET, CSR_INSTRET:            rd_data = minstret_val[31:0];
         CSR_MINSTRETH, CSR_INSTRETH:          rd_data = minstret_val[63:32];
         CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rd_data = '0;
         CSR_MHARTID:                          rd_data = XLEN'(HART_ID);
         default:                              impl = 1'b0;
      endcase
   end

   assign rd_illegal = !impl || (rd_wr_intent && rd_addr[11:10] == 2'b11);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_mie     <= 1'b0;
         st_mpie    <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RESET & MTVEC_MASK;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else if (trap_valid) begin
         mepc_q   <= trap_pc & EPC_MASK;
         mcause_q <= trap_cause;
         mtval_q  <= trap_tval;
         st_mpie  <= st_mie;
         st_mie   <= 1'b0;
      end else if (mret_valid) begin
         st_mie  <= st_mpie;
         st_mpie <= 1'b1;
      end else if (wr_en) begin
         case (wr_addr)
            CSR_MSTATUS: begin
               st_mie  <= wr_data[MSTATUS_MIE_BIT];
               st_mpie <= wr_data[MSTATUS_MPIE_BIT];
            end
            CSR_MIE:      mie_q <= {wr_data[IRQ_EXT_BIT], wr_data[IRQ_TMR_BIT], wr_data[IRQ_SW_BIT]};
            CSR_MTVEC:    mtvec_q <= wr_data & MTVEC_MASK;
            CSR_MSCRATCH: mscratch_q <= wr_data;
            CSR_MEPC:     mepc_q <= wr_data & EPC_MASK;
            CSR_MCAUSE:   mcause_q <= wr_data;
            CSR_MTVAL:    mtval_q <= wr_data;
            default: ;
         endcase
      end
   end

   csr_counter64 u_mcycle (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (1'b1),
      .wr_lo   (wr_commit && wr_addr == CSR_MCYCLE),
      .wr_hi   (wr_commit && wr_addr == CSR_MCYCLEH),
      .wr_data (wr_data),
      .value   (mcycle_val)
   );

   csr_counter64 u_minstret (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (instret_inc),
      .wr_lo   (wr_commit && wr_addr == CSR_MINSTRET),
      .wr_hi   (wr_commit && wr_addr == CSR_MINSTRETH),
      .wr_data (wr_data),
      .value   (minstret_val)
   );

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: expectations queued at stimulus time, popped and checked on the outputs.
module tb_csr_regfile;

   localparam logic [31:0] MTVEC_RST = 32'h0000_0080;
   localparam int          HART      = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] rd_addr = '0;
   logic [31:0] rd_data;
   logic        rd_illegal;
   logic        rd_wr_intent = 1'b0;
   logic        wr_en = 1'b0;
   logic [11:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        instret_inc = 1'b0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_cause = '0;
   logic [31:0] trap_pc = '0;
   logic [31:0] trap_tval = '0;
   logic        mret_valid = 1'b0;
   logic        irq_ext = 1'b0, irq_tmr = 1'b0, irq_sw = 1'b0;
   logic [31:0] trap_vector;
   logic [31:0] mepc_out;
   logic        irq_pending;

   csr_regfile #(.XLEN(32), .MTVEC_RESET(MTVEC_RST), .HART_ID(HART), .MISA_VAL(32'h4000_0100)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_illegal(rd_illegal),
      .rd_wr_intent(rd_wr_intent), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .instret_inc(instret_inc), .trap_valid(trap_valid), .trap_cause(trap_cause),
      .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
      .irq_ext(irq_ext), .irq_tmr(irq_tmr), .irq_sw(irq_sw),
      .trap_vector(trap_vector), .mepc_out(mepc_out), .irq_pending(irq_pending)
   );

   always #10 clk = ~clk;

   typedef enum int {K_RD, K_ILL, K_TVEC, K_MEPC, K_IRQ} kind_e;
   typedef struct {
      kind_e       kind;
      logic [11:0] addr;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic chk(input kind_e kind, input logic [11:0] addr, input logic [31:0] exp,
                      input string tag);
      exp_t        e;
      logic [31:0] obs;
      sb.push_back('{kind, addr, exp, tag});
      if (kind == K_RD || kind == K_ILL) rd_addr = addr;
      #1;
      e = sb.pop_front();
      case (e.kind)
         K_RD:    obs = rd_data;
         K_ILL:   obs = {31'b0, rd_illegal};
         K_TVEC:  obs = trap_vector;
         K_MEPC:  obs = mepc_out;
         default: obs = {31'b0, irq_pending};
      endcase
      n_total++;
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
   endtask

   task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = addr; wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk(K_RD,   12'h305, MTVEC_RST,       "reset_mtvec");
      chk(K_RD,   12'h300, 32'h0000_1800,   "reset_mstatus");
      chk(K_RD,   12'hF14, 32'(HART),       "reset_mhartid");
      chk(K_IRQ,  12'h000, 32'h0,           "reset_irq_pending");
      chk(K_MEPC, 12'h000, 32'h0,           "reset_mepc_out");
      chk(K_TVEC, 12'h000, MTVEC_RST,       "reset_trap_vector");
      chk(K_RD,   12'h301, 32'h4000_0100,   "misa");

      csr_write(12'h341, 32'h8000_0007);
      chk(K_RD,   12'h341, 32'h8000_0004,   "mepc_align");
      chk(K_MEPC, 12'h000, 32'h8000_0004,   "mepc_out_write");
      csr_write(12'h300, 32'hFFFF_FFFF);
      chk(K_RD,   12'h300, 32'h0000_1888,   "mstatus_mask");
      csr_write(12'h300, 32'h0000_0008);
      chk(K_RD,   12'h300, 32'h0000_1808,   "mstatus_mie_only");
      csr_write(12'h301, 32'h0);
      chk(K_RD,   12'h301, 32'h4000_0100,   "misa_write_ignored");
      csr_write(12'hF14, 32'hFFFF_FFFF);
      chk(K_RD,   12'hF14, 32'(HART),       "mhartid_write_ignored");
      csr_write(12'h305, 32'h0000_0203);
      chk(K_RD,   12'h305, 32'h0000_0201,   "mtvec_bit1_zero");
      csr_write(12'h340, 32'h1234_5678);
      chk(K_RD,   12'h340, 32'h1234_5678,   "mscratch");

      // Trap with a colliding mscratch write: trap wins, the write is dropped.
      @(negedge clk);
      trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_0102;
      trap_tval = 32'hDEAD_BEEF;
      wr_en = 1'b1; wr_addr = 12'h340; wr_data = 32'h0000_FFFF;
      chk(K_TVEC, 12'h000, 32'h0000_021C,   "trap_vector_vectored");
      @(negedge clk);
      trap_valid = 1'b0; wr_en = 1'b0;
      chk(K_RD,   12'h342, 32'h8000_0007,   "trap_mcause");
      chk(K_RD,   12'h341, 32'h0000_0100,   "trap_mepc");
      chk(K_RD,   12'h343, 32'hDEAD_BEEF,   "trap_mtval");
      chk(K_RD,   12'h300, 32'h0000_1880,   "trap_mstatus");
      chk(K_RD,   12'h340, 32'h1234_5678,   "trap_drops_write");
      trap_cause = 32'h0000_0005;
      chk(K_TVEC, 12'h000, 32'h0000_0200,   "trap_vector_exception");

      // mret with a colliding mstatus write: mret wins.
      @(negedge clk);
      mret_valid = 1'b1; wr_en = 1'b1; wr_addr = 12'h300; wr_data = 32'h0;
      @(negedge clk);
      mret_valid = 1'b0; wr_en = 1'b0;
      chk(K_RD,   12'h300, 32'h0000_1888,   "mret_mstatus");
      chk(K_MEPC, 12'h000, 32'h0000_0100,   "mret_target");

      csr_write(12'h304, 32'hFFFF_FFFF);
      chk(K_RD,   12'h304, 32'h0000_0888,   "mie_mask");
      irq_tmr = 1'b1;
      chk(K_RD,   12'h344, 32'h0000_0080,   "mip_tmr");
      chk(K_IRQ,  12'h000, 32'h1,           "irq_pending_tmr");
      irq_tmr = 1'b0;
      chk(K_IRQ,  12'h000, 32'h0,           "irq_pending_clear");
      irq_ext = 1'b1;
      csr_write(12'h300, 32'h0);
      chk(K_IRQ,  12'h000, 32'h0,           "irq_masked_by_mie");
      irq_ext = 1'b0;

      rd_wr_intent = 1'b1;
      chk(K_ILL,  12'hC00, 32'h1,           "illegal_ro_write");
      chk(K_ILL,  12'h340, 32'h0,           "legal_rw_write");
      rd_wr_intent = 1'b0;
      chk(K_ILL,  12'hC00, 32'h0,           "legal_ro_read");
      chk(K_ILL,  12'h7C0, 32'h1,           "illegal_unimpl");
      chk(K_RD,   12'h7C0, 32'h0,           "unimpl_reads_zero");

      csr_write(12'hB80, 32'h0);
      csr_write(12'hB00, 32'hFFFF_FFFF);
      chk(K_RD,   12'hB00, 32'hFFFF_FFFF,   "mcycle_written");
      chk(K_RD,   12'hB80, 32'h0,           "mcycleh_written");
      @(negedge clk);
      chk(K_RD,   12'hB80, 32'h1,           "mcycleh_wrap");
      chk(K_RD,   12'hB00, 32'h0,           "mcycle_wrap");
      chk(K_RD,   12'hC80, 32'h1,           "cycleh_shadow");

      instret_inc = 1'b1;
      csr_write(12'hB02, 32'h0000_0055);
      chk(K_RD,   12'hB02, 32'h0000_0055,   "minstret_write_wins");
      @(negedge clk);
      instret_inc = 1'b0;
      chk(K_RD,   12'hC02, 32'h0000_0056,   "instret_inc");
      @(negedge clk);
      chk(K_RD,   12'hB02, 32'h0000_0056,   "instret_hold");

      // Reset asserted while a write is pending discards it.
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 12'h340; wr_data = 32'hABCD_0123;
      #2 rst_n = 1'b0;
      @(negedge clk);
      wr_en = 1'b0;
      rst_n = 1'b1;
      chk(K_RD,   12'h340, 32'h0,           "reset_discards_write");
      chk(K_RD,   12'h305, MTVEC_RST,       "reset_mtvec_again");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
